// File: rtl/ula_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, flag
// bit positions and the double-dabble digit adjust used by the BCD converter.
package ula_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int FLAG_COUT = 0;
    localparam int FLAG_OV   = 1;
    localparam int FLAG_Z    = 2;
    localparam int FLAG_ERR  = 3;
    localparam int FLAG_NEG  = 4;
    localparam int FLAG_N    = 5;

    // add-3 correction applied to a BCD digit before each shift
    function automatic logic [3:0] bcd_adjust(input logic [3:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

endpackage

// File: rtl/ula_sequencial_bcd.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per cycle.
// start loads the value; done is high during the last shift cycle, and bcd
// updates on that edge and holds until the next conversion completes.
module bcd_serial
    import ula_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = $clog2(WIDTH);

    logic                  running;
    logic [CNT_W-1:0]      cnt;
    logic [WIDTH-1:0]      shreg;
    logic [4*DIGITS-1:0]   acc;
    logic [4*DIGITS-1:0]   acc_adj;
    logic [4*DIGITS-1:0]   acc_step;

    // one double-dabble step: adjust every digit, then shift in the next bit
    always_comb begin
        acc_adj = acc;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            acc_adj[4*d +: 4] = bcd_adjust(acc[4*d +: 4]);
        end
        acc_step = (4*DIGITS)'({acc_adj, shreg[WIDTH-1]});
        done     = running && (cnt == CNT_W'(WIDTH-1));
    end

    // conversion sequencing and result holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            cnt     <= '0;
            shreg   <= '0;
            acc     <= '0;
            bcd     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            shreg   <= value;
            acc     <= '0;
        end else if (running) begin
            shreg <= shreg << 1;
            acc   <= acc_step;
            cnt   <= cnt + CNT_W'(1);
            if (done) begin
                running <= 1'b0;
                bcd     <= acc_step;
            end
        end
    end

endmodule

// File: rtl/ula_sequencial.sv
// Sequential ALU: add/sub/logic in one cycle, shift-add multiply and
// restoring divide in WIDTH cycles, then optional serial BCD conversion of
// the result magnitude. Macro ULA_BCD_EN enables the BCD stage; without it
// the CONV state is skipped and bcd_out is tied to zero.
module ula_sequencial
    import ula_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int BCD_DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        a_in,
    input  logic [WIDTH-1:0]        b_in,
    input  logic                    cin,
    input  logic [2:0]              op_sel,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [2*WIDTH-1:0]      result,
    output logic [WIDTH-1:0]        remainder,
    output logic                    flag_cout,
    output logic                    flag_ov,
    output logic                    flag_z,
    output logic                    flag_err,
    output logic                    flag_neg,
    output logic [4*BCD_DIGITS-1:0] bcd_out
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t state;
    state_t state_next;

    logic                accept;
    logic                calc_en;
    logic                calc_last;
    logic                enter_done;
    logic                mul_div;

    logic [WIDTH-1:0]    a_r;
    logic [WIDTH-1:0]    b_r;
    logic                cin_r;
    logic [2:0]          op_r;
    logic [WIDTH-1:0]    hi;
    logic [WIDTH-1:0]    lo;
    logic [CNT_W-1:0]    cnt;

    logic [WIDTH-1:0]    hi_step;
    logic [WIDTH-1:0]    lo_step;
    logic [WIDTH:0]      sum;
    logic [WIDTH:0]      shifted;
    logic [WIDTH:0]      add_sum;
    logic [WIDTH:0]      sub_dif;

    logic [2*WIDTH-1:0]  res_next;
    logic [WIDTH-1:0]    rem_next;
    logic [FLAG_N-1:0]   flags_next;
    logic [FLAG_N-1:0]   flags_r;

`ifdef ULA_BCD_EN
    logic                conv_start;
    logic                conv_done;
    logic [2*WIDTH-1:0]  mag_next;
    logic [2*WIDTH-1:0]  res_w;
    logic [WIDTH-1:0]    rem_w;
    logic [FLAG_N-1:0]   flags_w;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = CALC;
            CALC: begin
                if (calc_last) begin
`ifdef ULA_BCD_EN
                    state_next = CONV;
`else
                    state_next = DONE;
`endif
                end
            end
            CONV: begin
`ifdef ULA_BCD_EN
                if (conv_done) state_next = DONE;
`else
                state_next = IDLE;
`endif
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs and datapath controls
    always_comb begin
        busy       = (state != IDLE);
        done       = (state == DONE);
        accept     = (state == IDLE) && start;
        calc_en    = (state == CALC);
        enter_done = (state != DONE) && (state_next == DONE);
`ifdef ULA_BCD_EN
        conv_start = calc_en && calc_last;
`endif
    end

    // one multiply or divide iteration on the shared hi/lo register pair
    always_comb begin
        hi_step = hi;
        lo_step = lo;
        sum     = '0;
        shifted = '0;
        if (op_r == OP_MUL) begin
            sum     = {1'b0, hi} + (lo[0] ? {1'b0, b_r} : '0);
            hi_step = sum[WIDTH:1];
            lo_step = {sum[0], lo[WIDTH-1:1]};
        end else begin
            shifted = {hi, lo[WIDTH-1]};
            if (shifted >= {1'b0, b_r}) begin
                hi_step = WIDTH'(shifted - {1'b0, b_r});
                lo_step = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_step = shifted[WIDTH-1:0];
                lo_step = {lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // final result and flags as they stand after the current CALC cycle
    always_comb begin
        mul_div    = (op_r == OP_MUL) || ((op_r == OP_DIV) && (b_r != '0));
        calc_last  = !mul_div || (cnt == CNT_W'(WIDTH-1));
        add_sum    = {1'b0, a_r} + {1'b0, b_r} + {{WIDTH{1'b0}}, cin_r};
        sub_dif    = {1'b0, a_r} - {1'b0, b_r} - {{WIDTH{1'b0}}, cin_r};
        res_next   = '0;
        rem_next   = '0;
        flags_next = '0;
        case (op_r)
            OP_ADD: begin
                res_next[WIDTH-1:0]  = add_sum[WIDTH-1:0];
                flags_next[FLAG_COUT] = add_sum[WIDTH];
                flags_next[FLAG_OV]   = (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                        (add_sum[WIDTH-1] != a_r[WIDTH-1]);
            end
            OP_SUB: begin
                res_next[WIDTH-1:0]  = sub_dif[WIDTH-1:0];
                flags_next[FLAG_COUT] = sub_dif[WIDTH];
                flags_next[FLAG_OV]   = (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                                        (sub_dif[WIDTH-1] != a_r[WIDTH-1]);
                flags_next[FLAG_NEG]  = sub_dif[WIDTH-1];
            end
            OP_AND: res_next[WIDTH-1:0] = a_r & b_r;
            OP_OR:  res_next[WIDTH-1:0] = a_r | b_r;
            OP_XOR: res_next[WIDTH-1:0] = a_r ^ b_r;
            OP_MUL: res_next = {hi_step, lo_step};
            OP_DIV: begin
                if (b_r == '0) begin
                    res_next[WIDTH-1:0]  = '1;
                    rem_next             = a_r;
                    flags_next[FLAG_ERR] = 1'b1;
                end else begin
                    res_next[WIDTH-1:0] = lo_step;
                    rem_next            = hi_step;
                end
            end
            OP_RSV:  res_next = '0;
            default: res_next = '0;
        endcase
        flags_next[FLAG_Z] = (res_next == '0);
`ifdef ULA_BCD_EN
        mag_next = res_next;
        if (flags_next[FLAG_NEG]) begin
            mag_next[WIDTH-1:0] = ~res_next[WIDTH-1:0] + WIDTH'(1);
        end
`endif
    end

    // operand capture on accept and iteration state during CALC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            cin_r <= 1'b0;
            op_r  <= OP_ADD;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
        end else if (accept) begin
            a_r   <= a_in;
            b_r   <= b_in;
            cin_r <= cin;
            op_r  <= op_sel;
            hi    <= '0;
            lo    <= a_in;
            cnt   <= '0;
        end else if (calc_en) begin
            hi  <= hi_step;
            lo  <= lo_step;
            cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef ULA_BCD_EN
    // hold the computed result while the BCD conversion runs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_w   <= '0;
            rem_w   <= '0;
            flags_w <= '0;
        end else if (calc_en && calc_last) begin
            res_w   <= res_next;
            rem_w   <= rem_next;
            flags_w <= flags_next;
        end
    end

    bcd_serial #(
        .WIDTH  (2*WIDTH),
        .DIGITS (BCD_DIGITS)
    ) u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .value (mag_next),
        .done  (conv_done),
        .bcd   (bcd_out)
    );
`else
    assign bcd_out = '0;
`endif

    // visible result registers, loaded on the edge entering DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            remainder <= '0;
            flags_r   <= '0;
        end else if (enter_done) begin
`ifdef ULA_BCD_EN
            result    <= res_w;
            remainder <= rem_w;
            flags_r   <= flags_w;
`else
            result    <= res_next;
            remainder <= rem_next;
            flags_r   <= flags_next;
`endif
        end
    end

    assign flag_cout = flags_r[FLAG_COUT];
    assign flag_ov   = flags_r[FLAG_OV];
    assign flag_z    = flags_r[FLAG_Z];
    assign flag_err  = flags_r[FLAG_ERR];
    assign flag_neg  = flags_r[FLAG_NEG];

endmodule
